period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_defs.sv | 17 +
 rtl/edge_sync.sv | 36 +++
 rtl/period_meter.sv | 114 +++++++++++
 tb/tb_period_meter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_defs.sv
// ============================================================================
// Module   : period_meter_defs
// Purpose  : State encodings shared by period_meter and later capture blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package period_meter_defs;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } pm_state_t;

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// ============================================================================
// Module   : edge_sync
// Purpose  : Two-flop synchronizer followed by a registered rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // rise is high for one cycle, three clocks after din first meets setup
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      rise   <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
      r_prev <= r_sync;
      rise   <= r_sync & ~r_prev;
    end
  end

endmodule

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// Module   : period_meter
// Purpose  : Measures the period of an asynchronous signal in clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_meter
  import period_meter_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 50000000,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] c_timeout    = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] c_min_period = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);

  logic             w_rise;
  pm_state_t        r_state,   w_state_nxt;
  logic [WIDTH-1:0] r_cnt,     w_cnt_nxt;
  logic [WIDTH-1:0] r_period,  w_period_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_locked,  w_locked_nxt;
  logic             r_timeout, w_timeout_nxt;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .rise (w_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = 1'b0;

    if (!en) begin
      w_state_nxt  = ST_IDLE;
      w_cnt_nxt    = '0;
      w_locked_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_COUNT;
            w_cnt_nxt   = c_one;
          end
        end
        ST_COUNT: begin
          // An accepted edge beats the timeout when both land on the same cycle
          if (w_rise && (r_cnt >= c_min_period)) begin
            w_period_nxt = r_cnt;
            w_valid_nxt  = 1'b1;
            w_locked_nxt = 1'b1;
            w_cnt_nxt    = c_one;
          end else if (r_cnt == c_timeout) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_one;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_cnt_nxt    = '0;
          w_locked_nxt = 1'b0;
        end
      endcase
    end
  end

  assign period  = r_period;
  assign valid   = r_valid;
  assign locked  = r_locked;
  assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
// Module   : tb_period_meter
// Purpose  : Directed and randomized checks of period_meter against a timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_period_meter;

  localparam int WIDTH      = 16;
  localparam int TIMEOUT    = 1000;
  localparam int MIN_PERIOD = 4;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             en     = 1'b0;
  logic             sig_in = 1'b0;
  logic [WIDTH-1:0] period;
  logic             valid;
  logic             locked;
  logic             timeout;

  always #5 clk = ~clk;

  period_meter #(
    .WIDTH      (WIDTH),
    .TIMEOUT    (TIMEOUT),
    .MIN_PERIOD (MIN_PERIOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sig_in  (sig_in),
    .period  (period),
    .valid   (valid),
    .locked  (locked),
    .timeout (timeout)
  );

  int vectors      = 0;
  int miscompares  = 0;
  int n            = 0;
  int valid_seen   = 0;
  int timeout_seen = 0;
  bit samp [0:131071];

  // Model: timestamp of the last arming/accepted edge, not a running counter
  bit m_active  = 1'b0;
  bit m_locked  = 1'b0;
  bit m_valid   = 1'b0;
  bit m_timeout = 1'b0;
  int m_tlast   = 0;
  int m_period  = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, n, got, exp);
    end
  endtask

  // A rising sig_in sampled at clock k reaches the FSM at clock k+3
  function automatic bit edge_at(input int k);
    if (k < 4) return 1'b0;
    return samp[k-3] && !samp[k-4];
  endfunction

  task automatic model_step(input bit r, input bit e);
    int el;
    m_valid   = 1'b0;
    m_timeout = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_locked = 1'b0;
      m_period = 0;
    end else if (!e) begin
      m_active = 1'b0;
      m_locked = 1'b0;
    end else if (!m_active) begin
      if (edge_at(n)) begin
        m_active = 1'b1;
        m_tlast  = n;
      end
    end else begin
      el = n - m_tlast;
      if (edge_at(n) && el >= MIN_PERIOD) begin
        m_period = el;
        m_valid  = 1'b1;
        m_locked = 1'b1;
        m_tlast  = n;
      end else if (el >= TIMEOUT) begin
        m_timeout = 1'b1;
        m_active  = 1'b0;
        m_locked  = 1'b0;
      end
    end
  endtask

  task automatic step(input bit s, input bit e, input bit r);
    sig_in = s;
    en     = e;
    rst    = r;
    @(posedge clk);
    n++;
    samp[n] = r ? 1'b0 : s;
    if (r) begin
      for (int k = 1; k <= 3; k++) if (n - k >= 0) samp[n-k] = 1'b0;
    end
    model_step(r, e);
    #1;
    check("valid",   int'(valid),   int'(m_valid));
    check("timeout", int'(timeout), int'(m_timeout));
    check("locked",  int'(locked),  int'(m_locked));
    check("period",  int'(period),  m_period);
    valid_seen   += int'(valid);
    timeout_seen += int'(timeout);
  endtask

  task automatic pulses(input int count, input int per, input bit e);
    for (int i = 0; i < count; i++) begin
      step(1'b1, e, 1'b0);
      for (int j = 1; j < per; j++) step(1'b0, e, 1'b0);
    end
  endtask

  task automatic idle_low(input int cycles, input bit e);
    for (int i = 0; i < cycles; i++) step(1'b0, e, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    check("rst_period", int'(period), 0);
    check("rst_locked", int'(locked), 0);

    // Five pulses at 100: first arms, four valid periods
    valid_seen = 0;
    pulses(5, 100, 1'b1);
    check("p100_valid_count", valid_seen, 4);
    check("p100_locked", int'(locked), 1);
    check("p100_period", int'(period), 100);

    // Glitch two cycles after a pulse must be ignored
    valid_seen = 0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle_low(97, 1'b1);
    pulses(1, 100, 1'b1);
    check("glitch_valid_count", valid_seen, 2);
    check("glitch_period", int'(period), 100);

    // Signal lost: one timeout strobe, period held
    timeout_seen = 0;
    idle_low(1100, 1'b1);
    check("loss_timeout_count", timeout_seen, 1);
    check("loss_locked", int'(locked), 0);
    check("loss_period", int'(period), 100);

    // Spacing exactly TIMEOUT is still a valid period
    timeout_seen = 0;
    valid_seen   = 0;
    pulses(4, 1000, 1'b1);
    check("t1000_timeouts", timeout_seen, 0);
    check("t1000_valid_count", valid_seen, 3);
    check("t1000_period", int'(period), 1000);
    timeout_seen = 0;
    pulses(3, 1001, 1'b1);
    check("t1001_saw_timeout", int'(timeout_seen > 0), 1);

    // Reset mid-measurement clears everything, next edge only arms
    pulses(3, 100, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle_low(49, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("rst_mid_period", int'(period), 0);
    check("rst_mid_locked", int'(locked), 0);
    valid_seen = 0;
    pulses(3, 100, 1'b1);
    check("rst_mid_valid_count", valid_seen, 2);
    check("rst_mid_result", int'(period), 100);

    // Enable dropped while locked
    valid_seen = 0;
    pulses(3, 100, 1'b0);
    check("en_low_valids", valid_seen, 0);
    check("en_low_locked", int'(locked), 0);
    pulses(3, 100, 1'b1);
    check("en_high_valids", valid_seen, 2);
    check("en_high_period", int'(period), 100);

    // Randomized segments: normal, near-timeout, glitchy, enable/reset disturbance
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom % 4)
        0: pulses(4, $urandom_range(4, 150), 1'b1);
        1: pulses(2, $urandom_range(995, 1005), 1'b1);
        2: pulses(6, $urandom_range(1, 6), 1'b1);
        default: begin
          if ($urandom % 2) idle_low($urandom_range(1, 50), 1'b0);
          else for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'b0, 1'b1, 1'b1);
        end
      endcase
    end
    idle_low(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
